mem_arbiter: RTL and testbench

Arbitrates the single off-chip main memory between the I-side and D-side `memory_system` instances. Grants exclusive read access for a full cache-block fill by driving each instance's `proceed` input. Steers the granted instance's miss address to memory and routes `memory_data_valid` back to that instance only. Also issues single-cycle D-side write-through stores when memory is idle.

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates off-chip main memory between the I-side and D-side memory systems:
// round-robin, non-preemptive block-fill grants plus D-side write-through stores issued while idle.
module mem_arbiter #(
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_busy,
    input  logic [15:0] icache_addr,
    input  logic        dcache_busy,
    input  logic [15:0] dcache_addr,
    input  logic        dcache_wr_req,
    input  logic [15:0] dcache_wr_addr,
    input  logic [15:0] dcache_wr_data,
    input  logic        mem_data_valid,
    output logic        icache_proceed,
    output logic        dcache_proceed,
    output logic        icache_data_valid,
    output logic        dcache_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        wr_stall
);
    localparam int unsigned CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANT_I = 2'b01;
    localparam logic [1:0] GRANT_D = 2'b10;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Reset leaves D as the last grant so the I-side wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SIDE_D;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Grant selection and fill counting; the counter wraps to zero on the last word.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (icache_busy && (!dcache_busy || (last_grant_q == SIDE_D))) begin
                    state_d      = GRANT_I;
                    last_grant_d = SIDE_I;
                end else if (dcache_busy) begin
                    state_d      = GRANT_D;
                    last_grant_d = SIDE_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_data_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Memory steering; stores only go out while idle and never while reset is held.
    always_comb begin
        icache_proceed    = 1'b0;
        dcache_proceed    = 1'b0;
        icache_data_valid = 1'b0;
        dcache_data_valid = 1'b0;
        mem_enable        = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = 16'h0000;
        mem_data_in       = 16'h0000;
        case (state_q)
            IDLE: begin
                if (dcache_wr_req && !rst) begin
                    mem_enable  = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = dcache_wr_addr;
                    mem_data_in = dcache_wr_data;
                end
            end
            GRANT_I: begin
                icache_proceed    = 1'b1;
                icache_data_valid = mem_data_valid;
                mem_enable        = icache_busy;
                mem_addr          = icache_addr;
            end
            GRANT_D: begin
                dcache_proceed    = 1'b1;
                dcache_data_valid = mem_data_valid;
                mem_enable        = dcache_busy;
                mem_addr          = dcache_addr;
            end
            default: ;
        endcase
        wr_stall = dcache_wr_req && (state_q != IDLE);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a directed vector table, corner-case sequences
// and randomized traffic, all compared against an ownership/word-count reference model.
module tb_mem_arbiter;
    localparam int unsigned BW = 8;

    typedef struct packed {
        logic        rst;
        logic        ib;
        logic [15:0] ia;
        logic        db;
        logic [15:0] da;
        logic        wq;
        logic [15:0] wa;
        logic [15:0] wd;
        logic        mdv;
    } in_t;

    typedef struct packed {
        logic        ip;
        logic        dp;
        logic        idv;
        logic        ddv;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        stall;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_busy, dcache_busy, dcache_wr_req, mem_data_valid;
    logic [15:0] icache_addr, dcache_addr, dcache_wr_addr, dcache_wr_data;
    logic        icache_proceed, dcache_proceed, icache_data_valid, dcache_data_valid;
    logic        mem_enable, mem_wr, wr_stall;
    logic [15:0] mem_addr, mem_data_in;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns memory, words received in the current fill, last winner.
    int owner  = 0;   // 0 none, 1 I-side, 2 D-side
    int got    = 0;
    bit last_d = 1'b1;
    out_t s;          // outputs sampled in the most recent step

    always #5 clk = ~clk;

    mem_arbiter #(.BLOCK_WORDS(BW)) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_busy       (icache_busy),
        .icache_addr       (icache_addr),
        .dcache_busy       (dcache_busy),
        .dcache_addr       (dcache_addr),
        .dcache_wr_req     (dcache_wr_req),
        .dcache_wr_addr    (dcache_wr_addr),
        .dcache_wr_data    (dcache_wr_data),
        .mem_data_valid    (mem_data_valid),
        .icache_proceed    (icache_proceed),
        .dcache_proceed    (dcache_proceed),
        .icache_data_valid (icache_data_valid),
        .dcache_data_valid (dcache_data_valid),
        .mem_enable        (mem_enable),
        .mem_wr            (mem_wr),
        .mem_addr          (mem_addr),
        .mem_data_in       (mem_data_in),
        .wr_stall          (wr_stall)
    );

    function automatic in_t mk(logic r, logic ib, logic [15:0] ia, logic db, logic [15:0] da,
                               logic wq, logic [15:0] wa, logic [15:0] wd, logic mdv);
        in_t v;
        v.rst = r; v.ib = ib; v.ia = ia; v.db = db; v.da = da;
        v.wq = wq; v.wa = wa; v.wd = wd; v.mdv = mdv;
        return v;
    endfunction

    function automatic out_t mko(logic ip, logic dp, logic idv, logic ddv, logic en, logic wr,
                                 logic [15:0] addr, logic [15:0] din, logic stall);
        out_t o;
        o.ip = ip; o.dp = dp; o.idv = idv; o.ddv = ddv; o.en = en; o.wr = wr;
        o.addr = addr; o.din = din; o.stall = stall;
        return o;
    endfunction

    function automatic out_t model_out(in_t v);
        out_t e = '0;
        if (v.rst) return e;
        if (owner == 0) begin
            if (v.wq) begin
                e.en = 1'b1; e.wr = 1'b1; e.addr = v.wa; e.din = v.wd;
            end
        end else if (owner == 1) begin
            e.ip = 1'b1; e.idv = v.mdv; e.en = v.ib; e.addr = v.ia; e.stall = v.wq;
        end else begin
            e.dp = 1'b1; e.ddv = v.mdv; e.en = v.db; e.addr = v.da; e.stall = v.wq;
        end
        return e;
    endfunction

    task automatic model_update(input in_t v);
        if (v.rst) begin
            owner = 0; got = 0; last_d = 1'b1;
        end else if (owner == 0) begin
            if (v.ib && v.db)  owner = last_d ? 1 : 2;
            else if (v.ib)     owner = 1;
            else if (v.db)     owner = 2;
            if (owner != 0)    last_d = (owner == 2);
        end else if (v.mdv) begin
            got = got + 1;
            if (got == int'(BW)) begin
                owner = 0; got = 0;
            end
        end
    endtask

    function automatic out_t dut_out();
        return mko(icache_proceed, dcache_proceed, icache_data_valid, dcache_data_valid,
                   mem_enable, mem_wr, mem_addr, mem_data_in, wr_stall);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input out_t a, input out_t e);
        chk({tag, ".icache_proceed"},    16'(a.ip),    16'(e.ip));
        chk({tag, ".dcache_proceed"},    16'(a.dp),    16'(e.dp));
        chk({tag, ".icache_data_valid"}, 16'(a.idv),   16'(e.idv));
        chk({tag, ".dcache_data_valid"}, 16'(a.ddv),   16'(e.ddv));
        chk({tag, ".mem_enable"},        16'(a.en),    16'(e.en));
        chk({tag, ".mem_wr"},            16'(a.wr),    16'(e.wr));
        chk({tag, ".mem_addr"},          a.addr,       e.addr);
        chk({tag, ".mem_data_in"},       a.din,        e.din);
        chk({tag, ".wr_stall"},          16'(a.stall), 16'(e.stall));
    endtask

    // Drive one cycle just after a rising edge, check at the falling edge, advance the model.
    task automatic step(input in_t v, input string tag, input bit use_t, input out_t texp);
        rst            = v.rst;
        icache_busy    = v.ib;
        icache_addr    = v.ia;
        dcache_busy    = v.db;
        dcache_addr    = v.da;
        dcache_wr_req  = v.wq;
        dcache_wr_addr = v.wa;
        dcache_wr_data = v.wd;
        mem_data_valid = v.mdv;
        #4;
        s = dut_out();
        check_outs({tag, ".model"}, s, model_out(v));
        if (use_t) check_outs({tag, ".table"}, s, texp);
        @(posedge clk);
        model_update(v);
        #1;
    endtask

    task automatic run(input in_t v, input string tag);
        step(v, tag, 1'b0, '0);
    endtask

    // Finish any open fill with valid pulses, bounded, then leave one quiet idle cycle.
    task automatic flush(input string tag);
        int n = 0;
        while (owner != 0 && n < 3 * int'(BW)) begin
            run(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 1), tag);
            n++;
        end
        checks++;
        if (owner != 0) begin
            errors++;
            $display("FAIL %s.flush_timeout actual=%0d expected=0", tag, owner);
        end
        run(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 0), tag);
    endtask

    vec_t tbl[$];

    initial begin
        int ip_cnt, dv_cnt, st_cnt, wr_cnt, issued;
        string order;
        bit prev_ip, prev_dp;

        rst = 1'b1; icache_busy = 0; dcache_busy = 0; dcache_wr_req = 0; mem_data_valid = 0;
        icache_addr = '0; dcache_addr = '0; dcache_wr_addr = '0; dcache_wr_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with a store request and stray valid present.
        step(mk(1, 1, 16'h1111, 1, 16'h2222, 1, 16'h3333, 16'h4444, 1), "reset", 1'b1, '0);
        run(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 0), "post_reset");

        // Directed table: store + D miss in one idle cycle, D fill, stray valid in idle, I grant.
        tbl.push_back('{mk(0, 0, 16'h0, 1, 16'h0100, 1, 16'h1234, 16'hBEEF, 0),
                        mko(0, 0, 0, 0, 1, 1, 16'h1234, 16'hBEEF, 0)});
        tbl.push_back('{mk(0, 0, 16'h0, 1, 16'h0100, 1, 16'h1234, 16'hBEEF, 1),
                        mko(0, 1, 0, 1, 1, 0, 16'h0100, 16'h0000, 1)});
        for (int k = 0; k < 7; k++)
            tbl.push_back('{mk(0, 1, 16'h0200, 0, 16'h0100, 0, 16'h0, 16'h0, 1),
                            mko(0, 1, 0, 1, 0, 0, 16'h0100, 16'h0000, 0)});
        tbl.push_back('{mk(0, 1, 16'h0200, 0, 16'h0100, 0, 16'h0, 16'h0, 1),
                        mko(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0)});
        tbl.push_back('{mk(0, 1, 16'h0200, 0, 16'h0100, 0, 16'h0, 16'h0, 0),
                        mko(1, 0, 0, 0, 1, 0, 16'h0200, 16'h0000, 0)});
        foreach (tbl[k]) step(tbl[k].i, $sformatf("tbl%0d", k), 1'b1, tbl[k].o);
        flush("tbl_flush");

        // I-only miss with four cycles of memory latency before eight valids.
        ip_cnt = 0; dv_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            run(mk(0, c < 13, 16'h0A00 + 16'(c), 0, 16'h0, 0, 16'h0, 16'h0, c >= 5 && c <= 12), "imiss");
            ip_cnt += int'(s.ip);
            dv_cnt += int'(s.ddv);
        end
        chk("imiss.proceed_cycles", 16'(ip_cnt), 16'd12);
        chk("imiss.dcache_valid_cycles", 16'(dv_cnt), 16'd0);

        // Both sides continuously busy right after reset: grants alternate starting with I.
        run(mk(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 0), "rr_reset");
        order = ""; prev_ip = 0; prev_dp = 0;
        for (int c = 0; c < 36; c++) begin
            run(mk(0, 1, 16'($urandom), 1, 16'($urandom), 0, 16'h0, 16'h0, 1), "rr");
            if (s.ip && !prev_ip) order = {order, "I"};
            if (s.dp && !prev_dp) order = {order, "D"};
            prev_ip = s.ip; prev_dp = s.dp;
        end
        checks++;
        if (order != "IDID") begin
            errors++;
            $display("FAIL rr.grant_order actual=%s expected=IDID", order);
        end
        flush("rr_flush");

        // Store requested mid I-fill stalls until the first idle cycle, then issues once.
        run(mk(0, 1, 16'h0C00, 0, 16'h0, 0, 16'h0, 16'h0, 0), "st_grant");
        for (int c = 0; c < 3; c++) run(mk(0, 1, 16'h0C00, 0, 16'h0, 0, 16'h0, 16'h0, 1), "st_fill");
        st_cnt = 0; issued = 0;
        for (int c = 0; c < 20 && issued == 0; c++) begin
            run(mk(0, 1, 16'h0C00, 0, 16'h0, 1, 16'h1234, 16'hBEEF, 1), "st_wait");
            st_cnt += int'(s.stall);
            if (s.wr) begin
                issued = 1;
                chk("st.issue_addr", s.addr, 16'h1234);
                chk("st.issue_data", s.din, 16'hBEEF);
            end
        end
        chk("st.issued", 16'(issued), 16'd1);
        chk("st.stall_cycles", 16'(st_cnt), 16'd5);
        wr_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            run(mk(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 16'h0, 1), "st_after");
            wr_cnt += int'(s.wr);
        end
        chk("st.extra_writes", 16'(wr_cnt), 16'd0);
        flush("st_flush");

        // Reset after the third valid of a D fill, then a clean full I fill.
        run(mk(0, 0, 16'h0, 1, 16'h0D00, 0, 16'h0, 16'h0, 0), "rst_grant");
        for (int c = 0; c < 3; c++) run(mk(0, 0, 16'h0, 1, 16'h0D00, 0, 16'h0, 16'h0, 1), "rst_fill");
        step(mk(1, 0, 16'h0, 1, 16'h0D00, 1, 16'h5555, 16'h6666, 1), "rst_mid", 1'b1, '0);
        ip_cnt = 0; dv_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            run(mk(0, c < 9, 16'h0E00, 0, 16'h0, 0, 16'h0, 16'h0, c >= 1 && c <= 8), "rst_refill");
            ip_cnt += int'(s.ip);
            dv_cnt += int'(s.idv);
        end
        chk("rst.refill_proceed_cycles", 16'(ip_cnt), 16'd8);
        chk("rst.refill_valids", 16'(dv_cnt), 16'd8);
        flush("rst_flush");

        // Randomized traffic including occasional asynchronous resets.
        for (int c = 0; c < 800; c++) begin
            run(mk($urandom_range(99) == 0, $urandom_range(2) == 0, 16'($urandom),
                   $urandom_range(2) == 0, 16'($urandom), $urandom_range(3) == 0,
                   16'($urandom), 16'($urandom), $urandom_range(1) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
